// File: rtl/clk_prescaler_pkg.sv
// Shared definitions for the synchronous clock prescaler: mode encodings and Gray helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block family).
package clk_prescaler_pkg;

    // Counter wrap behaviour selected by the mode pin.
    localparam logic MODE_FREE = 1'b0;   // wrap at all-ones
    localparam logic MODE_MOD  = 1'b1;   // wrap at the loaded terminal count

    // Widest window the Gray helper converts; callers zero-extend narrower windows.
    localparam int GRAY_MAX_W = 32;

    // Binary to reflected Gray code. Zero-extension is harmless: the top bit of a
    // narrower window is XORed with a zero, which is the correct Gray MSB.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/clk_prescaler_tapsel.sv
// Selects NUM_TAPS adjacent counter bits starting at a clamped base index (optional Gray coding).
// Latency: combinational; the parent registers the result.
// Backpressure: none. Gray output enabled by defining CLK_PRESCALER_GRAY_EN.
module clk_prescaler_tapsel
    import clk_prescaler_pkg::*;
#(
    parameter int WIDTH    = 15,
    parameter int NUM_TAPS = 8,
    parameter int BASE_W   = 4
) (
    input  logic [WIDTH-1:0]    cnt,
    input  logic [BASE_W-1:0]   tap_base,
    output logic [NUM_TAPS-1:0] win
);

    // Highest legal base index: the window must stay inside the counter.
    localparam int              MAX_BASE_I = WIDTH - NUM_TAPS;
    localparam logic [BASE_W-1:0] MAX_BASE = BASE_W'(MAX_BASE_I);

    logic [BASE_W-1:0]   eff_base;
    logic [NUM_TAPS-1:0] sel;

    // Clamp the requested base so an out-of-range request maps onto the top window.
    always_comb begin
        eff_base = tap_base;
        if (tap_base > MAX_BASE) begin
            eff_base = MAX_BASE;
        end
    end

    // Window mux built from constant part-selects; every candidate is in range.
    always_comb begin
        sel = '0;
        for (int b = 0; b <= MAX_BASE_I; b++) begin
            if (eff_base == BASE_W'(b)) begin
                sel = cnt[b +: NUM_TAPS];
            end
        end
    end

    // Optional Gray coding so exactly one output bit moves per window increment.
    always_comb begin
`ifdef CLK_PRESCALER_GRAY_EN
        win = NUM_TAPS'(bin2gray(GRAY_MAX_W'(sel)));
`else
        win = sel;
`endif
    end

endmodule

// File: rtl/clk_prescaler_taps.sv
// Single-clock prescaler: free-run or modulo-N counter, registered tap window and wrap tick.
// Latency: tick one cycle after the wrapping edge; tap_out lags the counter by one cycle.
// Backpressure: none; en stalls the counter. Gray taps when CLK_PRESCALER_GRAY_EN is defined.
module clk_prescaler_taps
    import clk_prescaler_pkg::*;
#(
    parameter int WIDTH    = 15,   // counter stages
    parameter int NUM_TAPS = 8,    // exported adjacent bits, NUM_TAPS <= WIDTH
    parameter int BASE_W   = 4     // 2**BASE_W >= WIDTH-NUM_TAPS+1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                mode,
    input  logic                load,
    input  logic [WIDTH-1:0]    div_value,
    input  logic [BASE_W-1:0]   tap_base,
    output logic [NUM_TAPS-1:0] tap_out,
    output logic                tick
);

    localparam logic [WIDTH-1:0] CNT_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_nxt;
    logic [WIDTH-1:0]    mod_q;
    logic                tick_nxt;
    logic [NUM_TAPS-1:0] win;

    // Next counter value and wrap flag; clr beats load beats en, idle cycles drop tick.
    always_comb begin
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        if (clr || load) begin
            cnt_nxt = '0;
        end else if (en) begin
            case (mode)
                MODE_FREE: begin
                    cnt_nxt  = cnt + CNT_ONE;
                    tick_nxt = (cnt == CNT_ONES);
                end
                MODE_MOD: begin
                    // >= rather than == so a count left above mod_q wraps at once.
                    if (cnt >= mod_q) begin
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= tick_nxt;
        end
    end

    // Terminal count register; load captures even when clr wins the counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_q <= CNT_ONES;
        end else if (load) begin
            mod_q <= div_value;
        end
    end

    clk_prescaler_tapsel #(
        .WIDTH    (WIDTH),
        .NUM_TAPS (NUM_TAPS),
        .BASE_W   (BASE_W)
    ) u_tapsel (
        .cnt      (cnt),
        .tap_base (tap_base),
        .win      (win)
    );

    // Register the selected window so the pins never see mux glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_out <= '0;
        end else begin
            tap_out <= win;
        end
    end

endmodule

// File: tb/tb_clk_prescaler_taps.sv
// Directed bench for clk_prescaler_taps with default parameters (WIDTH=15, NUM_TAPS=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected tap values follow the Gray option when CLK_PRESCALER_GRAY_EN is defined.
module tb_clk_prescaler_taps;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        mode;
    logic        load;
    logic [14:0] div_value;
    logic [3:0]  tap_base;
    logic [7:0]  tap_out;
    logic        tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_prescaler_taps dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .load      (load),
        .div_value (div_value),
        .tap_base  (tap_base),
        .tap_out   (tap_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Expected pin value for counter value c with requested base (clamped to 7).
    function automatic logic [7:0] exp_win(input logic [14:0] c, input int base);
        int          eff;
        logic [14:0] s;
        logic [7:0]  w;
        eff = (base > 7) ? 7 : base;
        s   = c >> eff;
        w   = s[7:0];
`ifdef CLK_PRESCALER_GRAY_EN
        w   = w ^ (w >> 1);
`endif
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b0; load = 1'b0;
        div_value = '0; tap_base = '0;
        #2;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (tap_out !== 8'h00) begin n_fail++; $display("FAIL reset_tap[%0d]: got %h want 00", i, tap_out); end
            n_checks++;
            if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick[%0d]: got %b want 0", i, tick); end
            step();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        int ticks_seen;
        en = 1'b1; mode = 1'b0; tap_base = 4'd0;
        for (int n = 1; n <= 256; n++) begin
            step();
            n_checks++;
            if (tap_out !== exp_win(15'(n - 1), 0)) begin
                n_fail++; $display("FAIL free_tap n=%0d: got %h want %h", n, tap_out, exp_win(15'(n - 1), 0));
            end
            n_checks++;
            if (tick !== 1'b0) begin n_fail++; $display("FAIL free_tick n=%0d: got %b want 0", n, tick); end
        end
        ticks_seen = 0;
        for (int n = 257; n <= 32767; n++) begin
            step();
            if (tick !== 1'b0) ticks_seen++;
        end
        n_checks++;
        if (ticks_seen != 0) begin n_fail++; $display("FAIL free_early_ticks: got %0d want 0", ticks_seen); end
        step();  // edge 32768: counter wraps from 0x7fff
        n_checks++;
        if (tick !== 1'b1) begin n_fail++; $display("FAIL free_wrap_tick: got %b want 1", tick); end
        n_checks++;
        if (tap_out !== exp_win(15'h7fff, 0)) begin
            n_fail++; $display("FAIL free_wrap_tap: got %h want %h", tap_out, exp_win(15'h7fff, 0));
        end
        step();
        n_checks++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL free_post_wrap_tick: got %b want 0", tick); end
        n_checks++;
        if (tap_out !== exp_win(15'h0000, 0)) begin
            n_fail++; $display("FAIL free_post_wrap_tap: got %h want %h", tap_out, exp_win(15'h0000, 0));
        end
        en = 1'b0;
    endtask

    task automatic test_modulo();
        logic exp_t;
        div_value = 15'd4; mode = 1'b1; en = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL mod_load_tick: got %b want 0", tick); end
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_t = (k % 5 == 0);
            n_checks++;
            if (tap_out !== exp_win(15'((k - 1) % 5), 0)) begin
                n_fail++; $display("FAIL mod_tap k=%0d: got %h want %h", k, tap_out, exp_win(15'((k - 1) % 5), 0));
            end
            n_checks++;
            if (tick !== exp_t) begin n_fail++; $display("FAIL mod_tick k=%0d: got %b want %b", k, tick, exp_t); end
        end
        // counter now 2; stall three cycles
        en = 1'b0;
        for (int h = 0; h < 3; h++) begin
            step();
            n_checks++;
            if (tap_out !== exp_win(15'd2, 0)) begin
                n_fail++; $display("FAIL mod_hold_tap h=%0d: got %h want %h", h, tap_out, exp_win(15'd2, 0));
            end
            n_checks++;
            if (tick !== 1'b0) begin n_fail++; $display("FAIL mod_hold_tick h=%0d: got %b want 0", h, tick); end
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_t = (k == 2);
            n_checks++;
            if (tap_out !== exp_win(15'(2 + k), 0)) begin
                n_fail++; $display("FAIL mod_resume_tap k=%0d: got %h want %h", k, tap_out, exp_win(15'(2 + k), 0));
            end
            n_checks++;
            if (tick !== exp_t) begin n_fail++; $display("FAIL mod_resume_tick k=%0d: got %b want %b", k, tick, exp_t); end
        end
    endtask

    task automatic test_div1();
        div_value = 15'd0; load = 1'b1; mode = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (tick !== 1'b1) begin n_fail++; $display("FAIL div1_tick k=%0d: got %b want 1", k, tick); end
            n_checks++;
            if (tap_out !== 8'h00) begin n_fail++; $display("FAIL div1_tap k=%0d: got %h want 00", k, tap_out); end
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (tick !== 1'b0) begin n_fail++; $display("FAIL div1_idle_tick k=%0d: got %b want 0", k, tick); end
        end
        en = 1'b1;
        step();
        n_checks++;
        if (tick !== 1'b1) begin n_fail++; $display("FAIL div1_resume_tick: got %b want 1", tick); end
    endtask

    task automatic test_mode_switch();
        int early;
        div_value = 15'd10; load = 1'b1; mode = 1'b0; en = 1'b1;
        step();
        load = 1'b0;
        early = 0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (tick !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL sw_free_ticks: got %0d want 0", early); end
        n_checks++;
        if (tap_out !== exp_win(15'd99, 0)) begin
            n_fail++; $display("FAIL sw_tap_at_100: got %h want %h", tap_out, exp_win(15'd99, 0));
        end
        mode = 1'b1;
        step();
        n_checks++;
        if (tick !== 1'b1) begin n_fail++; $display("FAIL sw_wrap_tick: got %b want 1", tick); end
        n_checks++;
        if (tap_out !== exp_win(15'd100, 0)) begin
            n_fail++; $display("FAIL sw_wrap_tap: got %h want %h", tap_out, exp_win(15'd100, 0));
        end
        step();
        n_checks++;
        if (tap_out !== exp_win(15'd0, 0)) begin
            n_fail++; $display("FAIL sw_restart_tap: got %h want %h", tap_out, exp_win(15'd0, 0));
        end
        // counter is 1; ticks again when it wraps from 10
        early = 0;
        for (int n = 0; n < 9; n++) begin
            step();
            if (tick !== 1'b0) early++;
        end
        step();
        n_checks++;
        if (early != 0 || tick !== 1'b1) begin
            n_fail++; $display("FAIL sw_mod10_period: early=%0d tick=%b want early=0 tick=1", early, tick);
        end
    endtask

    task automatic test_clr_load();
        logic exp_t;
        clr = 1'b1; load = 1'b1; div_value = 15'd7; en = 1'b1; mode = 1'b1;
        step();
        clr = 1'b0; load = 1'b0;
        n_checks++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL cl_tick: got %b want 0", tick); end
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_t = (k == 8);
            n_checks++;
            if (tap_out !== exp_win(15'(k - 1), 0) || tick !== exp_t) begin
                n_fail++;
                $display("FAIL cl_mod7 k=%0d: got tap=%h tick=%b want tap=%h tick=%b",
                         k, tap_out, tick, exp_win(15'(k - 1), 0), exp_t);
            end
        end
        step(); step(); step();  // counter now 3
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (tap_out !== exp_win(15'd3, 0) || tick !== 1'b0) begin
            n_fail++; $display("FAIL clr_edge: got tap=%h tick=%b want tap=%h tick=0", tap_out, tick, exp_win(15'd3, 0));
        end
        step();
        n_checks++;
        if (tap_out !== exp_win(15'd0, 0)) begin
            n_fail++; $display("FAIL clr_after: got %h want %h", tap_out, exp_win(15'd0, 0));
        end
    endtask

    task automatic test_tap_clamp();
        mode = 1'b0; en = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0; tap_base = 4'd15;
        for (int n = 1; n <= 400; n++) begin
            step();
            n_checks++;
            if (tap_out !== exp_win(15'(n - 1), 15)) begin
                n_fail++; $display("FAIL clamp_tap n=%0d: got %h want %h", n, tap_out, exp_win(15'(n - 1), 15));
            end
        end
        n_checks++;
        if (tap_out !== exp_win(15'd3, 0)) begin  // 399 >> 7 = 3
            n_fail++; $display("FAIL clamp_tap_400: got %h want %h", tap_out, exp_win(15'd3, 0));
        end
        tap_base = 4'd3;
        step();
        n_checks++;
        if (tap_out !== exp_win(15'd50, 0)) begin  // 400 >> 3 = 50
            n_fail++; $display("FAIL base3: got %h want %h", tap_out, exp_win(15'd50, 0));
        end
        tap_base = 4'd5;
        step();
        n_checks++;
        if (tap_out !== exp_win(15'd12, 0)) begin  // 401 >> 5 = 12
            n_fail++; $display("FAIL base5: got %h want %h", tap_out, exp_win(15'd12, 0));
        end
        tap_base = 4'd8;
        step();
        n_checks++;
        if (tap_out !== exp_win(15'd3, 0)) begin  // clamped to 7: 402 >> 7 = 3
            n_fail++; $display("FAIL base8_clamp: got %h want %h", tap_out, exp_win(15'd3, 0));
        end
        tap_base = 4'd0;
    endtask

    task automatic test_async_reset();
        int stray;
        div_value = 15'd0; load = 1'b1; mode = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (tick !== 1'b1) begin n_fail++; $display("FAIL ar_pre_tick: got %b want 1", tick); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL ar_tick_async: got %b want 0", tick); end
        step();
        rst_n = 1'b1;
        mode = 1'b0; tap_base = 4'd0; en = 1'b1;
        for (int n = 1; n <= 4660; n++) step();  // counter now 0x1234
        n_checks++;
        if (tap_out !== exp_win(15'h1233, 0)) begin
            n_fail++; $display("FAIL ar_pre_tap: got %h want %h", tap_out, exp_win(15'h1233, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tap_out !== 8'h00 || tick !== 1'b0) begin
            n_fail++; $display("FAIL ar_async_clear: got tap=%h tick=%b want tap=00 tick=0", tap_out, tick);
        end
        step();
        rst_n = 1'b1;
        // mod_q must be back to all-ones: no early wrap in modulo mode
        mode = 1'b1;
        stray = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (tick !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0 || tap_out !== exp_win(15'd19, 0)) begin
            n_fail++; $display("FAIL ar_restart: got tap=%h ticks=%0d want tap=%h ticks=0", tap_out, stray, exp_win(15'd19, 0));
        end
    endtask

`ifdef CLK_PRESCALER_GRAY_EN
    task automatic test_gray();
        logic [7:0] prev;
        mode = 1'b0; en = 1'b1; tap_base = 4'd0; clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        prev = tap_out;
        for (int n = 0; n < 300; n++) begin
            step();
            n_checks++;
            if ($countones(tap_out ^ prev) != 1) begin
                n_fail++; $display("FAIL gray_step n=%0d: got %h after %h want one bit change", n, tap_out, prev);
            end
            prev = tap_out;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_modulo();
        test_div1();
        test_mode_switch();
        test_clr_load();
        test_tap_clamp();
        test_async_reset();
`ifdef CLK_PRESCALER_GRAY_EN
        test_gray();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
